regbank_sweeper: RTL

//  Initiator/driver for the 2-read/1-write register bank (BancoRegistro port set).
//  On start: writes a seed-based pattern into every address, then reads back
//  two registers per cycle via both read ports and checks them.

---
 rtl/regbank_sweeper.sv | 118 +++++++++++
 1 files changed

// File: rtl/regbank_sweeper.sv
// Self-test engine for a 2-read/1-write register bank: writes a seed-based
// pattern into every address, then reads it back two registers per cycle.
module regbank_sweeper #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic [AW-1:0] addrW,
  output logic [DW-1:0] datW,
  output logic          RegWrite,
  output logic [AW-1:0] addrRa,
  output logic [AW-1:0] addrRb,
  input  logic [DW-1:0] datOutRa,
  input  logic [DW-1:0] datOutRb,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] errAddr,
  output logic [AW:0]   errCount
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int          HALF_I = 2 ** (AW - 1);
  localparam int          LAST_I = 2 ** AW - 1;
  localparam logic [AW-1:0] HALF    = HALF_I[AW-1:0];
  localparam logic [AW-1:0] LAST    = LAST_I[AW-1:0];
  localparam logic [AW-1:0] LAST_RD = HALF - 1'b1;

  logic [1:0]    state;
  logic [DW-1:0] seedQ;
  logic          mA, mB;

  // exp(a) = (seed + a) mod 2**DW, computed wide enough for any AW/DW mix
  function automatic logic [DW-1:0] expOf(input logic [DW-1:0] s, input logic [AW-1:0] a);
    logic [AW+DW-1:0] sum;
    sum = {{AW{1'b0}}, s} + {{DW{1'b0}}, a};
    return sum[DW-1:0];
  endfunction

  assign mA = (datOutRa != expOf(seedQ, addrRa));
  assign mB = (datOutRb != expOf(seedQ, addrRb));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      seedQ    <= '0;
      addrW    <= '0;
      datW     <= '0;
      RegWrite <= 1'b0;
      addrRa   <= '0;
      addrRb   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      errAddr  <= '0;
      errCount <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= WRITE;
            seedQ    <= seed;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            errAddr  <= '0;
            errCount <= '0;
            RegWrite <= 1'b1;
            addrW    <= '0;
            datW     <= seed;
            addrRa   <= '0;
            addrRb   <= '0;
          end
        end
        WRITE: begin
          if (addrW == LAST) begin
            state    <= READ;
            RegWrite <= 1'b0;
            addrW    <= '0;
            datW     <= '0;
            addrRa   <= '0;
            addrRb   <= HALF;
          end else begin
            addrW <= addrW + 1'b1;
            datW  <= expOf(seedQ, addrW + 1'b1);
          end
        end
        READ: begin
          errCount <= errCount + {{AW{1'b0}}, mA} + {{AW{1'b0}}, mB};
          // Only the first mismatch is recorded; port A wins a same-cycle tie
          if (!err && (mA || mB)) begin
            err     <= 1'b1;
            errAddr <= mA ? addrRa : addrRb;
          end
          if (addrRa == LAST_RD) begin
            state  <= DONE;
            addrRa <= '0;
            addrRb <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            addrRa <= addrRa + 1'b1;
            addrRb <= addrRb + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
